// File: rtl/riscv_pipe_ctrl.sv
// riscv_pipe_ctrl: stall/flush controller for the 5-stage RV32I pipeline.
//
// Each cycle it decides whether the PC, IF/ID and ID/EX advance, hold or bubble.
// It follows a state machine: INIT after reset, RUN in normal operation, and
// DROP while a wrong-path fetch is still in flight. It also keeps saturating
// stall and redirect counters.
//
// Ports:
//   i_clk, i_rstn             clock, asynchronous active-low reset
//   i_id_rs1/rs2, i_id_use_*  source registers of the instruction in ID
//   i_ex_rd, i_ex_is_load     destination register and load flag of the EX instruction
//   i_ex_redirect             taken branch or jump resolved in EX
//   i_imem_ack                fetch data valid this cycle
//   i_dmem_busy               data memory not ready; the whole pipeline freezes
//   i_cnt_clr                 synchronous clear of both counters
//   o_pc_stall, o_id_stall, o_id_flush, o_ex_stall, o_ex_flush, o_pc_redirect
//                             zero-latency combinational pipeline controls
//   o_stall_cnt, o_redirect_cnt   saturating performance counters
module riscv_pipe_ctrl #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned INIT_CYC = 2
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic [4:0]      i_id_rs1,
    input  logic [4:0]      i_id_rs2,
    input  logic            i_id_use_rs1,
    input  logic            i_id_use_rs2,
    input  logic [4:0]      i_ex_rd,
    input  logic            i_ex_is_load,
    input  logic            i_ex_redirect,
    input  logic            i_imem_ack,
    input  logic            i_dmem_busy,
    input  logic            i_cnt_clr,
    output logic            o_pc_stall,
    output logic            o_id_stall,
    output logic            o_id_flush,
    output logic            o_ex_stall,
    output logic            o_ex_flush,
    output logic            o_pc_redirect,
    output logic [XLEN-1:0] o_stall_cnt,
    output logic [XLEN-1:0] o_redirect_cnt
);

    localparam int unsigned ICW = 4;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ICW-1:0]    init_cnt_q, init_cnt_d;
    logic [XLEN-1:0]   stall_cnt_q, stall_cnt_d;
    logic [XLEN-1:0]   redirect_cnt_q, redirect_cnt_d;
    logic              load_use;

    // Load-use hazard: the ID instruction needs a value the EX load has not produced yet
    assign load_use = i_ex_is_load && (i_ex_rd != 5'd0) &&
                      ((i_id_use_rs1 && (i_id_rs1 == i_ex_rd)) ||
                       (i_id_use_rs2 && (i_id_rs2 == i_ex_rd)));

    // State and counter registers
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q        <= ST_INIT;
            init_cnt_q     <= '0;
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            init_cnt_q     <= init_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    // Next state and pipeline control outputs
    always_comb begin
        state_d       = state_q;
        init_cnt_d    = init_cnt_q;
        o_pc_stall    = 1'b0;
        o_id_stall    = 1'b0;
        o_id_flush    = 1'b0;
        o_ex_stall    = 1'b0;
        o_ex_flush    = 1'b0;
        o_pc_redirect = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                o_pc_stall = 1'b1;
                o_id_flush = 1'b1;
                o_ex_flush = 1'b1;
                if (init_cnt_q == ICW'(INIT_CYC - 1)) begin
                    state_d    = ST_RUN;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = ICW'(init_cnt_q + 1'b1);
                end
            end

            ST_RUN: begin
                if (i_dmem_busy) begin
                    // EX is frozen, so a pending redirect re-presents once busy drops
                    o_pc_stall = 1'b1;
                    o_id_stall = 1'b1;
                    o_ex_stall = 1'b1;
                end else if (i_ex_redirect) begin
                    o_pc_redirect = 1'b1;
                    o_id_flush    = 1'b1;
                    o_ex_flush    = 1'b1;
                    // An unanswered fetch is wrong-path and must be discarded on arrival
                    if (!i_imem_ack) begin
                        state_d = ST_DROP;
                    end
                end else if (load_use) begin
                    o_pc_stall = 1'b1;
                    o_id_stall = 1'b1;
                    o_ex_flush = 1'b1;
                end else if (!i_imem_ack) begin
                    o_pc_stall = 1'b1;
                    o_id_flush = 1'b1;
                end
            end

            ST_DROP: begin
                o_pc_stall = 1'b1;
                o_id_flush = 1'b1;
                o_ex_stall = i_dmem_busy;
                if (i_imem_ack) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d    = ST_INIT;
                init_cnt_d = '0;
            end
        endcase
    end

    // Saturating performance counters; clear wins over increment
    always_comb begin
        stall_cnt_d    = stall_cnt_q;
        redirect_cnt_d = redirect_cnt_q;
        if (i_cnt_clr) begin
            stall_cnt_d    = '0;
            redirect_cnt_d = '0;
        end else begin
            if ((state_q != ST_INIT) && o_pc_stall && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + XLEN'(1);
            end
            if (o_pc_redirect && (redirect_cnt_q != '1)) begin
                redirect_cnt_d = redirect_cnt_q + XLEN'(1);
            end
        end
    end

    assign o_stall_cnt    = stall_cnt_q;
    assign o_redirect_cnt = redirect_cnt_q;

endmodule
